// File: rtl/pact_lsu_port_arbiter_if.sv
// Bundle of the core-side LPI channels and the single cache access channel.
// The arbiter sits on the slave modport; whoever drives cores and cache uses master.
interface pact_lsu_port_arbiter_if #(
  parameter int NUM_PORT = 2,
  parameter int BW_QDATA = 64,
  parameter int BW_YDATA = 32
);
  logic [NUM_PORT-1:0]          core_rlqvalid_list;
  logic [NUM_PORT-1:0]          core_rlqready_list;
  logic [NUM_PORT-1:0]          core_rlqafy_list;
  logic [NUM_PORT*BW_QDATA-1:0] core_rlqdata_list;
  logic [NUM_PORT-1:0]          core_rlyvalid_list;
  logic [NUM_PORT-1:0]          core_rlyready_list;
  logic [NUM_PORT-1:0]          core_rlylast_list;
  logic [NUM_PORT*BW_YDATA-1:0] core_rlydata_list;
  logic                         access_slqvalid;
  logic                         access_slqready;
  logic                         access_slqafy;
  logic [BW_QDATA-1:0]          access_slqdata;
  logic                         access_slyvalid;
  logic                         access_slyready;
  logic                         access_slylast;
  logic [BW_YDATA-1:0]          access_slydata;

  modport slave (
    input  core_rlqvalid_list, core_rlqafy_list, core_rlqdata_list, core_rlyready_list,
    input  access_slqready, access_slyvalid, access_slylast, access_slydata,
    output core_rlqready_list, core_rlyvalid_list, core_rlylast_list, core_rlydata_list,
    output access_slqvalid, access_slqafy, access_slqdata, access_slyready
  );

  modport master (
    output core_rlqvalid_list, core_rlqafy_list, core_rlqdata_list, core_rlyready_list,
    output access_slqready, access_slyvalid, access_slylast, access_slydata,
    input  core_rlqready_list, core_rlyvalid_list, core_rlylast_list, core_rlydata_list,
    input  access_slqvalid, access_slqafy, access_slqdata, access_slyready
  );
endinterface

// File: rtl/pact_lsu_port_arbiter.sv
// Merges NUM_PORT core request channels into one cache access channel and routes
// replies back through an in-order tag FIFO of issuing ports.
// Optional macro PACT_LSU_PORT_PRIORITY_EN adds priority_mode (fixed lowest-index priority).
module pact_lsu_port_arbiter #(
  parameter int NUM_PORT  = 2,
  parameter int BW_QDATA  = 64,
  parameter int BW_YDATA  = 32,
  parameter int DEPTH_TAG = 4
) (
  input  logic clk,
  input  logic rstnn,
  input  logic clear,
`ifdef PACT_LSU_PORT_PRIORITY_EN
  input  logic priority_mode,
`endif
  pact_lsu_port_arbiter_if.slave bus,
  output logic busy,
  output logic error
);
  localparam int BW_PORT = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
  localparam int BW_TPTR = $clog2(DEPTH_TAG);
  localparam int BW_CNT  = BW_TPTR + 1;

  logic [BW_PORT-1:0] r_rr_ptr;
  logic               r_lock_valid;
  logic [BW_PORT-1:0] r_lock_port;
  logic [BW_PORT-1:0] r_tag_mem [DEPTH_TAG];
  logic [BW_TPTR-1:0] r_wr_ptr;
  logic [BW_TPTR-1:0] r_rd_ptr;
  logic [BW_CNT-1:0]  r_count;
  logic               r_error;

  logic               w_prio;
  logic               w_full;
  logic               w_empty;
  logic [NUM_PORT-1:0] w_eligible;
  logic [BW_PORT-1:0] w_start;
  logic [BW_PORT-1:0] w_cand;
  logic [BW_PORT-1:0] w_grant;
  logic               w_grant_valid;
  logic               w_hs;
  logic               w_push;
  logic               w_pop;
  logic [BW_PORT-1:0] w_head;

`ifdef PACT_LSU_PORT_PRIORITY_EN
  assign w_prio = priority_mode;
`else
  assign w_prio = 1'b0;
`endif

  // Port index advanced by off, wrapping at NUM_PORT (NUM_PORT need not be a power of two).
  function automatic logic [BW_PORT-1:0] wrap_add(input logic [BW_PORT-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_PORT) s = s - NUM_PORT;
    return BW_PORT'(s);
  endfunction

  assign w_full     = (r_count == BW_CNT'(DEPTH_TAG));
  assign w_empty    = (r_count == '0);
  // A read may only issue while a tag slot is free; a pop in the same cycle does not help.
  assign w_eligible = bus.core_rlqvalid_list & ~(bus.core_rlqafy_list & {NUM_PORT{w_full}});
  assign w_start    = w_prio ? '0 : r_rr_ptr;

  // Grant selection: locked port while a request is stalled, else first eligible from w_start.
  always_comb begin
    w_grant       = '0;
    w_grant_valid = 1'b0;
    w_cand        = '0;
    if (r_lock_valid) begin
      w_grant       = r_lock_port;
      w_grant_valid = w_eligible[r_lock_port];
    end else begin
      for (int k = 0; k < NUM_PORT; k++) begin
        w_cand = wrap_add(w_start, k);
        if (!w_grant_valid && w_eligible[w_cand]) begin
          w_grant       = w_cand;
          w_grant_valid = 1'b1;
        end
      end
    end
  end

  assign w_hs                = w_grant_valid & bus.access_slqready;
  assign bus.access_slqvalid = w_grant_valid;
  assign bus.access_slqafy   = w_grant_valid & bus.core_rlqafy_list[w_grant];
  assign bus.access_slqdata  = w_grant_valid ? bus.core_rlqdata_list[w_grant*BW_QDATA +: BW_QDATA] : '0;
  assign w_push              = w_hs & bus.access_slqafy;

  // Only the granted port sees the cache ready.
  always_comb begin
    bus.core_rlqready_list = '0;
    if (w_grant_valid) bus.core_rlqready_list[w_grant] = bus.access_slqready;
  end

  assign w_head = r_tag_mem[r_rd_ptr];

  // Reply steering by head tag; with no tag outstanding the reply is swallowed.
  always_comb begin
    bus.core_rlyvalid_list = '0;
    bus.core_rlylast_list  = '0;
    bus.access_slyready    = bus.access_slyvalid;
    if (!w_empty) begin
      bus.core_rlyvalid_list[w_head] = bus.access_slyvalid;
      bus.core_rlylast_list[w_head]  = bus.access_slylast;
      bus.access_slyready            = bus.core_rlyready_list[w_head];
    end
  end

  assign bus.core_rlydata_list = {NUM_PORT{bus.access_slydata}};
  assign w_pop = ~w_empty & bus.access_slyvalid & bus.access_slyready & bus.access_slylast;

  // Round-robin pointer and grant lock.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_rr_ptr     <= '0;
      r_lock_valid <= 1'b0;
      r_lock_port  <= '0;
    end else if (clear) begin
      r_rr_ptr     <= '0;
      r_lock_valid <= 1'b0;
      r_lock_port  <= '0;
    end else begin
      if (w_hs && !w_prio) r_rr_ptr <= wrap_add(w_grant, 1);
      if (w_hs) begin
        r_lock_valid <= 1'b0;
      end else if (w_grant_valid) begin
        r_lock_valid <= 1'b1;
        r_lock_port  <= w_grant;
      end
    end
  end

  // Tag FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Tag storage; contents are meaningless until pointed at, so no reset.
  always_ff @(posedge clk) begin
    if (w_push && !clear) r_tag_mem[r_wr_ptr] <= w_grant;
  end

  // Sticky flag for a reply nobody asked for; only reset clears it.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) r_error <= 1'b0;
    else if (w_empty && bus.access_slyvalid) r_error <= 1'b1;
  end

  assign busy  = (r_count != '0) | (|bus.core_rlqvalid_list);
  assign error = r_error;
endmodule

// File: tb/tb_pact_lsu_port_arbiter.sv
// Directed scenarios plus randomized traffic checked against a queue-based reference.
module tb_pact_lsu_port_arbiter;
  localparam int NP = 2;
  localparam int BQ = 64;
  localparam int BY = 32;
  localparam int DT = 4;

  logic clk = 1'b0;
  logic rstnn;
  logic clear;
  logic busy;
  logic error;
`ifdef PACT_LSU_PORT_PRIORITY_EN
  logic priority_mode;
`endif

  always #5 clk = ~clk;

  pact_lsu_port_arbiter_if #(.NUM_PORT(NP), .BW_QDATA(BQ), .BW_YDATA(BY)) bus ();

  pact_lsu_port_arbiter #(.NUM_PORT(NP), .BW_QDATA(BQ), .BW_YDATA(BY), .DEPTH_TAG(DT)) dut (
    .clk(clk),
    .rstnn(rstnn),
    .clear(clear),
`ifdef PACT_LSU_PORT_PRIORITY_EN
    .priority_mode(priority_mode),
`endif
    .bus(bus),
    .busy(busy),
    .error(error)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference state
  int m_rr;
  int m_lock;
  int m_q[$];
  bit m_err;
  // per-cycle predictions
  int p_g;
  bit p_gv, p_hs, p_push, p_pop, p_errset;

  logic [NP-1:0] pend;
  logic [NP-1:0] s_afy;
  logic [BQ-1:0] s_data [NP];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit prio_on();
`ifdef PACT_LSU_PORT_PRIORITY_EN
    return priority_mode;
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle();
    clear = 1'b0;
    bus.core_rlqvalid_list = '0;
    bus.core_rlqafy_list   = '0;
    bus.core_rlqdata_list  = '0;
    bus.core_rlyready_list = '0;
    bus.access_slqready    = 1'b0;
    bus.access_slyvalid    = 1'b0;
    bus.access_slylast     = 1'b0;
    bus.access_slydata     = '0;
`ifdef PACT_LSU_PORT_PRIORITY_EN
    priority_mode = 1'b0;
`endif
  endtask

  // Predict every output from the reference state and current inputs, and compare.
  task automatic evaluate();
    bit full;
    bit [NP-1:0] elig;
    int start, idx, h;
    logic [NP-1:0] e_rdy, e_rv, e_rl;
    logic e_syr;
    logic [BQ-1:0] e_qd;
    full = (m_q.size() >= DT);
    for (int i = 0; i < NP; i++)
      elig[i] = bus.core_rlqvalid_list[i] && (!bus.core_rlqafy_list[i] || !full);
    p_gv = 1'b0;
    p_g  = 0;
    if (m_lock >= 0) begin
      p_g  = m_lock;
      p_gv = elig[m_lock];
    end else begin
      start = prio_on() ? 0 : m_rr;
      for (int k = 0; k < NP; k++) begin
        idx = (start + k) % NP;
        if (!p_gv && elig[idx]) begin
          p_g  = idx;
          p_gv = 1'b1;
        end
      end
    end
    p_hs   = p_gv && bus.access_slqready;
    p_push = p_hs && bus.core_rlqafy_list[p_g];
    e_rdy = '0;
    if (p_gv && bus.access_slqready) e_rdy[p_g] = 1'b1;
    e_qd = p_gv ? bus.core_rlqdata_list[p_g*BQ +: BQ] : '0;
    chk("slqvalid", bus.access_slqvalid, p_gv);
    chk("slqafy", bus.access_slqafy, p_gv ? bus.core_rlqafy_list[p_g] : 1'b0);
    chk("slqdata", bus.access_slqdata, e_qd);
    chk("rlqready", bus.core_rlqready_list, e_rdy);
    e_rv = '0;
    e_rl = '0;
    p_pop = 1'b0;
    p_errset = 1'b0;
    if (m_q.size() > 0) begin
      h = m_q[0];
      e_rv[h] = bus.access_slyvalid;
      e_rl[h] = bus.access_slylast;
      e_syr = bus.core_rlyready_list[h];
      p_pop = bus.access_slyvalid && e_syr && bus.access_slylast;
    end else begin
      e_syr = bus.access_slyvalid;
      p_errset = bus.access_slyvalid;
    end
    chk("rlyvalid", bus.core_rlyvalid_list, e_rv);
    chk("rlylast", bus.core_rlylast_list, e_rl);
    chk("slyready", bus.access_slyready, e_syr);
    chk("rlydata", bus.core_rlydata_list, {NP{bus.access_slydata}});
    chk("busy", busy, (m_q.size() != 0) || (|bus.core_rlqvalid_list));
    chk("error", error, m_err);
  endtask

  task automatic update();
    if (p_errset) m_err = 1'b1;
    if (clear) begin
      m_q.delete();
      m_rr = 0;
      m_lock = -1;
    end else begin
      if (p_pop) void'(m_q.pop_front());
      if (p_push) m_q.push_back(p_g);
      if (p_hs && !prio_on()) m_rr = (p_g + 1) % NP;
      if (p_hs) m_lock = -1;
      else if (p_gv) m_lock = p_g;
    end
  endtask

  task automatic settle();
    #1;
    evaluate();
  endtask

  task automatic tick();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic clear_cycle();
    idle();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rstnn = 1'b0;
    m_q.delete();
    m_rr = 0;
    m_lock = -1;
    m_err = 1'b0;
    #1;
    evaluate();
    chk("rst_error", error, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_slyready", bus.access_slyready, 1'b0);
    @(negedge clk);
    rstnn = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_req(input int p, input bit v, input bit a, input logic [BQ-1:0] d);
    bus.core_rlqvalid_list[p] = v;
    bus.core_rlqafy_list[p]   = a;
    bus.core_rlqdata_list[p*BQ +: BQ] = d;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstnn = 1'b0;
    idle();
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // alternating grants with both ports writing continuously
    clear_cycle();
    set_req(0, 1'b1, 1'b0, 64'hA0A0_0000_0000_0001);
    set_req(1, 1'b1, 1'b0, 64'hB1B1_0000_0000_0002);
    bus.access_slqready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("t1_alternate", bus.core_rlqready_list, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
    end

    // lock holds a stalled request even when round-robin would move on
    clear_cycle();
    set_req(0, 1'b1, 1'b0, 64'h0000_0000_0000_1111);
    bus.access_slqready = 1'b1;
    step();
    set_req(0, 1'b1, 1'b0, 64'h0000_0000_0000_2222);
    bus.access_slqready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t2_stall_data", bus.access_slqdata, 64'h2222);
      tick();
    end
    set_req(1, 1'b1, 1'b0, 64'h0000_0000_0000_3333);
    settle();
    chk("t2_lock_data", bus.access_slqdata, 64'h2222);
    tick();
    bus.access_slqready = 1'b1;
    settle();
    chk("t2_lock_hs", bus.core_rlqready_list, 2'b01);
    tick();
    settle();
    chk("t2_next_port1", bus.core_rlqready_list, 2'b10);
    tick();

    // full tag FIFO blocks reads, writes pass, pop unblocks next cycle
    clear_cycle();
    set_req(0, 1'b1, 1'b1, 64'h0000_0000_0000_0ABC);
    bus.access_slqready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("t3_fill", bus.core_rlqready_list, 2'b01);
      tick();
    end
    settle();
    chk("t3_full_block", bus.core_rlqready_list, 2'b00);
    tick();
    set_req(1, 1'b1, 1'b0, 64'h0000_0000_0000_0DEF);
    settle();
    chk("t3_write_pass", bus.core_rlqready_list, 2'b10);
    tick();
    set_req(1, 1'b0, 1'b0, '0);
    bus.access_slyvalid = 1'b1;
    bus.access_slylast  = 1'b1;
    bus.access_slydata  = 32'hCAFE_0001;
    bus.core_rlyready_list = 2'b01;
    settle();
    chk("t3_pop_rly", bus.core_rlyvalid_list, 2'b01);
    chk("t3_block_on_pop", bus.core_rlqready_list, 2'b00);
    tick();
    bus.access_slyvalid = 1'b0;
    bus.access_slylast  = 1'b0;
    settle();
    chk("t3_unblock", bus.core_rlqready_list, 2'b01);
    tick();

    // two-beat replies routed in issue order
    clear_cycle();
    bus.access_slqready = 1'b1;
    set_req(1, 1'b1, 1'b1, 64'h1);
    step();
    set_req(1, 1'b0, 1'b0, '0);
    set_req(0, 1'b1, 1'b1, 64'h2);
    settle();
    chk("t4_port0_issue", bus.core_rlqready_list, 2'b01);
    tick();
    set_req(0, 1'b0, 1'b0, '0);
    bus.core_rlyready_list = 2'b11;
    for (int b = 0; b < 4; b++) begin
      bus.access_slyvalid = 1'b1;
      bus.access_slylast  = (b % 2 == 1);
      bus.access_slydata  = $urandom;
      settle();
      chk("t4_beat", bus.core_rlyvalid_list, (b < 2) ? 2'b10 : 2'b01);
      tick();
    end
    idle();
    settle();
    chk("t4_drained_busy", busy, 1'b0);
    tick();

`ifdef PACT_LSU_PORT_PRIORITY_EN
    // fixed priority keeps port0 winning
    clear_cycle();
    priority_mode = 1'b1;
    set_req(0, 1'b1, 1'b0, 64'h5);
    set_req(1, 1'b1, 1'b0, 64'h6);
    bus.access_slqready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t6_prio_port0", bus.core_rlqready_list, 2'b01);
      tick();
    end
    set_req(0, 1'b0, 1'b0, '0);
    settle();
    chk("t6_prio_port1", bus.core_rlqready_list, 2'b10);
    tick();
    idle();
`endif

    // stray reply: dropped, sticky error survives clear, reset clears it
    clear_cycle();
    bus.access_slyvalid = 1'b1;
    bus.access_slylast  = 1'b1;
    settle();
    chk("t5_drop_ready", bus.access_slyready, 1'b1);
    chk("t5_no_rly", bus.core_rlyvalid_list, 2'b00);
    tick();
    idle();
    settle();
    chk("t5_error_set", error, 1'b1);
    tick();
    clear_cycle();
    settle();
    chk("t5_error_kept", error, 1'b1);
    tick();
    do_reset();

    // randomized protocol-respecting traffic
    pend = '0;
    for (int c = 0; c < 600; c++) begin
      clear = ($urandom_range(0, 99) == 0);
`ifdef PACT_LSU_PORT_PRIORITY_EN
      priority_mode = ((c / 100) % 2 == 1);
`endif
      for (int i = 0; i < NP; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]   = 1'b1;
          s_afy[i]  = $urandom_range(0, 1);
          s_data[i] = {$urandom, $urandom};
        end
        set_req(i, pend[i], pend[i] ? s_afy[i] : 1'b0, pend[i] ? s_data[i] : '0);
      end
      bus.access_slqready    = ($urandom_range(0, 3) != 0);
      bus.access_slyvalid    = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      bus.access_slylast     = $urandom_range(0, 1);
      bus.access_slydata     = $urandom;
      bus.core_rlyready_list = NP'($urandom);
      step();
      if (p_hs) pend[p_g] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pact_lsu_port_arbiter.md
# pact_lsu_port_arbiter

Multi-port front end for the PACT load/store path. It merges `NUM_PORT` core-side LPI request channels into the single access channel that feeds the parallel cache, and routes each reply back to the port that issued it. An in-order tag FIFO holds the issuing port of every outstanding reply-expecting request. It is the N-core successor to the single-core LSU node.

## Interface
- `NUM_PORT`, 2: number of core-side ports, 1..8.
- `BW_QDATA`, 64: request payload width (address + write data + burden).
- `BW_YDATA`, 32: reply payload width.
- `DEPTH_TAG`, 4: outstanding reply-expecting requests, power of two, ≥2.
- `clk` in 1: clock.
- `rstnn` in 1: asynchronous active-low reset.
- `clear` in 1: synchronous flush of tag FIFO and arbiter state.
- `core_rlqvalid_list` in NUM_PORT: per-port request valid.
- `core_rlqready_list` out NUM_PORT: per-port request ready.
- `core_rlqafy_list` in NUM_PORT: per-port "reply expected" (read).
- `core_rlqdata_list` in NUM_PORT*BW_QDATA: per-port request payload.
- `core_rlyvalid_list` out NUM_PORT: per-port reply valid.
- `core_rlyready_list` in NUM_PORT: per-port reply ready.
- `core_rlylast_list` out NUM_PORT: per-port reply last beat.
- `core_rlydata_list` out NUM_PORT*BW_YDATA: reply payload, broadcast to all ports.
- `access_slqvalid` out 1, `access_slqready` in 1, `access_slqafy` out 1, `access_slqdata` out BW_QDATA: merged request to cache.
- `access_slyvalid` in 1, `access_slyready` out 1, `access_slylast` in 1, `access_slydata` in BW_YDATA: reply from cache.
- `busy` out 1: tag count ≠ 0 or any request valid.
- `error` out 1: sticky, set by a reply arriving with empty tag FIFO.

## Operation
- Registered state: RR pointer `rr_ptr` (log2 NUM_PORT bits), grant lock `lock_valid`/`lock_port`, tag FIFO (DEPTH_TAG × log2 NUM_PORT), count 0..DEPTH_TAG, `error`.
- Eligible port: `rlqvalid` = 1, and if `rlqafy` = 1 then count < DEPTH_TAG.
- Arbitration: when not locked, grant the first eligible port at or after `rr_ptr`, in ascending order with wrap. When locked, grant is `lock_port`.
- Lock: grant shown while `access_slqready` = 0 sets lock. The lock clears on handshake, so the payload never switches mid-request.
- Forwarding: `access_slqvalid`/`afy`/`data` come from the granted port. `core_rlqready[g]` = `access_slqready`; other ready bits are 0.
- On request handshake: `rr_ptr` ← g+1 mod NUM_PORT. If afy = 1, push g into the tag FIFO.
- Full FIFO blocks afy = 1 requests even if a pop happens in the same cycle. Writes (afy = 0) still pass.
- Reply routing: with count > 0, head tag h selects the port. `core_rlyvalid[h]` = `access_slyvalid`, `access_slyready` = `core_rlyready[h]`, and `rlylast` follows the same routing.
- Pop on `access_slyvalid & access_slyready & access_slylast`. Multi-beat replies stay on one port until last.
- Simultaneous push and pop (not full): count is unchanged, and head/tail pointers both advance with wrap.
- Empty FIFO with reply valid: `access_slyready` = 1 (drop), `error` ← 1, no core `rlyvalid`.
- `clear`: pointers, count, lock and `rr_ptr` ← 0. `error` is kept. Replies already in flight are then dropped and flagged.

## Timing
- Request and reply paths are combinational (0-cycle), with no added latency.
- Tag push is visible to the reply path in the cycle after the handshake.
- Reset (async, `rstnn` = 0): `rr_ptr` = 0, count = 0, lock = 0, `error` = 0.
- With inputs idle after reset, every output is 0, including all ready/valid and `busy`.
- Reset mid-transaction discards all tags. Upstream and cache reset together by convention.
- NUM_PORT = 1: arbiter degenerates to a pass-through. The tag FIFO still enforces DEPTH_TAG and error detection.

## Configuration
- `PACT_LSU_PORT_PRIORITY_EN` defined: adds input `priority_mode` (1 bit).
  - `priority_mode` = 1: fixed priority, lowest index wins, and `rr_ptr` is frozen.
  - `priority_mode` = 0: round-robin as above.
- Not defined: port absent, round-robin only.

## Test plan
- Two ports, both afy = 0 continuously, `access_slqready` = 1 → grants alternate 0,1,0,1; four handshakes in 4 cycles.
- Port0 valid, `access_slqready` low 3 cycles, then port1 also valid → port0 held (lock) until its handshake, then port1 is granted next.
- Four afy = 1 requests with DEPTH_TAG = 4 and no replies → fifth afy request blocked (`rlqready` = 0) while a port1 write passes. One single-beat reply pops the tag and unblocks next cycle.
- Reads from port1 then port0, each with 2-beat replies → beats 1–2 appear only on port1, beats 3–4 only on port0; count returns to 0.
- `access_slyvalid` = 1 with count = 0 → `access_slyready` = 1, no core `rlyvalid`, `error` = 1 and held through `clear`, cleared by `rstnn`.
- With the macro and `priority_mode` = 1, both ports valid for 3 requests → port0 granted all 3; port1 only after port0 deasserts.
